// File: rtl/alien_fleet_if.sv
// rtl/alien_fleet_if.sv - control/status bundle between the alien fleet sequencer and its host
interface alien_fleet_if #(
  parameter int COLS = 8,
  parameter int ROWS = 4
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N + 1);

  logic          vsync;
  logic          start;
  logic          hit_valid;
  logic [CW-1:0] hit_col;
  logic [RW-1:0] hit_row;
  logic          hit_ack;
  logic [9:0]    fleet_x;
  logic [9:0]    fleet_y;
  logic          fleet_dir;
  logic [N-1:0]  alive;
  logic [AW-1:0] alive_count;
  logic          step_pulse;
  logic          cleared;
  logic          landed;

  modport master (
    output vsync, start, hit_valid, hit_col, hit_row,
    input  hit_ack, fleet_x, fleet_y, fleet_dir, alive, alive_count,
           step_pulse, cleared, landed
  );

  modport slave (
    input  vsync, start, hit_valid, hit_col, hit_row,
    output hit_ack, fleet_x, fleet_y, fleet_dir, alive, alive_count,
           step_pulse, cleared, landed
  );
endinterface

// File: rtl/alien_fleet_ctrl.sv
// rtl/alien_fleet_ctrl.sv - alien formation sequencer; FLEET_SPEEDUP_EN selects alive-count-driven step period
module alien_fleet_ctrl #(
  parameter int COLS        = 8,
  parameter int ROWS        = 4,
  parameter int ALIEN_W     = 32,
  parameter int ALIEN_H     = 24,
  parameter int START_X     = 64,
  parameter int START_Y     = 40,
  parameter int X_MIN       = 8,
  parameter int X_MAX       = 632,
  parameter int STEP_X      = 8,
  parameter int STEP_Y      = 16,
  parameter int BOTTOM_Y    = 424,
  parameter int MIN_PERIOD  = 2,
  parameter int BASE_PERIOD = 20
) (
  input  logic         clk,
  input  logic         reset,
  alien_fleet_if.slave bus
);
  localparam int N    = ROWS * COLS;
  localparam int CW   = $clog2(COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int IW   = $clog2(N);
  localparam int AW   = $clog2(N + 1);
  localparam int PMAX = (MIN_PERIOD + N > BASE_PERIOD) ? (MIN_PERIOD + N) : BASE_PERIOD;
  localparam int FW   = $clog2(PMAX + 1);

  localparam logic [CW:0] NCOL = (CW + 1)'(COLS);
  localparam logic [RW:0] NROW = (RW + 1)'(ROWS);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] CLEARED = 2'd2;
  localparam logic [1:0] LANDED  = 2'd3;

  logic [1:0]    state;
  logic [9:0]    fx_r, fy_r;
  logic          dir_r;
  logic [N-1:0]  alive_r;
  logic [AW-1:0] count_r;
  logic [FW-1:0] fcnt_r;
  logic          hit_ack_r, step_r, cleared_r, landed_r;
  logic          vsync_q;

  logic          frame_tick;
  logic [FW-1:0] period;
  logic          step_due;
  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;
  logic [CW-1:0] lcol, rcol;
  logic [RW-1:0] brow;
  logic [11:0]   right_edge, left_edge, land_edge;
  logic [9:0]    fy_down;
  logic          descend, landing;
  logic [IW-1:0] hit_idx;
  logic          hit_in_range, hit_ok, last_kill;

  // previous vsync level for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vsync_q <= 1'b0;
    else       vsync_q <= bus.vsync;
  end

  assign frame_tick = bus.vsync & ~vsync_q;

`ifdef FLEET_SPEEDUP_EN
  assign period = FW'(MIN_PERIOD) + FW'(count_r);
`else
  assign period = FW'(BASE_PERIOD);
`endif

  // >= rather than == so the counter catches up if the period shrank below it
  assign step_due = (fcnt_r >= period - FW'(1));

  // which columns and rows still hold at least one alive cell
  always_comb begin
    col_any = '0;
    row_any = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (alive_r[r*COLS+c]) begin
          col_any[c] = 1'b1;
          row_any[r] = 1'b1;
        end
      end
    end
  end

  // leftmost / rightmost occupied column and lowest occupied row
  always_comb begin
    lcol = '0;
    rcol = '0;
    brow = '0;
    for (int c = COLS - 1; c >= 0; c--) if (col_any[c]) lcol = CW'(c);
    for (int c = 0; c < COLS; c++)      if (col_any[c]) rcol = CW'(c);
    for (int r = 0; r < ROWS; r++)      if (row_any[r]) brow = RW'(r);
  end

  // edges are evaluated at 12 bits so the left test cannot wrap below zero
  assign right_edge = 12'(fx_r) + (12'(rcol) + 12'd1) * 12'(ALIEN_W) + 12'(STEP_X);
  assign left_edge  = 12'(fx_r) + 12'(lcol) * 12'(ALIEN_W);
  assign descend    = dir_r ? (left_edge < 12'(X_MIN + STEP_X)) : (right_edge > 12'(X_MAX));
  assign fy_down    = fy_r + 10'(STEP_Y);
  assign land_edge  = 12'(fy_down) + (12'(brow) + 12'd1) * 12'(ALIEN_H);
  assign landing    = (land_edge >= 12'(BOTTOM_Y));

  assign hit_in_range = ({1'b0, bus.hit_col} < NCOL) && ({1'b0, bus.hit_row} < NROW);
  assign hit_idx      = IW'(bus.hit_row) * IW'(COLS) + IW'(bus.hit_col);
  assign hit_ok       = (state == RUN) && bus.hit_valid && hit_in_range && alive_r[hit_idx];
  assign last_kill    = hit_ok && (count_r == AW'(1));

  // fleet state machine: start, hit arbitration and march stepping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fx_r      <= 10'(START_X);
      fy_r      <= 10'(START_Y);
      dir_r     <= 1'b0;
      alive_r   <= '0;
      count_r   <= '0;
      fcnt_r    <= '0;
      hit_ack_r <= 1'b0;
      step_r    <= 1'b0;
      cleared_r <= 1'b0;
      landed_r  <= 1'b0;
    end else begin
      hit_ack_r <= 1'b0;
      step_r    <= 1'b0;
      if (bus.start) begin
        state     <= RUN;
        fx_r      <= 10'(START_X);
        fy_r      <= 10'(START_Y);
        dir_r     <= 1'b0;
        alive_r   <= '1;
        count_r   <= AW'(N);
        fcnt_r    <= '0;
        cleared_r <= 1'b0;
        landed_r  <= 1'b0;
      end else if (state == RUN) begin
        if (hit_ok) begin
          alive_r[hit_idx] <= 1'b0;
          count_r          <= count_r - AW'(1);
          hit_ack_r        <= 1'b1;
        end
        if (last_kill) begin
          state     <= CLEARED;
          cleared_r <= 1'b1;
        end else if (frame_tick) begin
          if (step_due) begin
            fcnt_r <= '0;
            step_r <= 1'b1;
            if (descend) begin
              fy_r  <= fy_down;
              dir_r <= ~dir_r;
              if (landing) begin
                state    <= LANDED;
                landed_r <= 1'b1;
              end
            end else if (dir_r) begin
              fx_r <= fx_r - 10'(STEP_X);
            end else begin
              fx_r <= fx_r + 10'(STEP_X);
            end
          end else begin
            fcnt_r <= fcnt_r + FW'(1);
          end
        end
      end
    end
  end

  assign bus.hit_ack     = hit_ack_r;
  assign bus.fleet_x     = fx_r;
  assign bus.fleet_y     = fy_r;
  assign bus.fleet_dir   = dir_r;
  assign bus.alive       = alive_r;
  assign bus.alive_count = count_r;
  assign bus.step_pulse  = step_r;
  assign bus.cleared     = cleared_r;
  assign bus.landed      = landed_r;
endmodule
